// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS pipeline: operand forwarding, ALU,
// branch/jump resolution and the EX/MEM pipeline register.
module ex_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        id_ex_rs,
    input  logic [4:0]        id_ex_rt,
    input  logic [4:0]        id_ex_rd,
    input  logic [4:0]        id_ex_shamt,
    input  logic [DATA_W-1:0] id_ex_imm_sign_extended,
    input  logic [25:0]       id_ex_jump_index,
    input  logic [DATA_W-1:0] id_ex_reg_a_data,
    input  logic [DATA_W-1:0] id_ex_reg_b_data,
    input  logic [DATA_W-1:0] id_ex_pc_next,
    input  logic [3:0]        id_ex_ctrl_alu_control,
    input  logic              id_ex_ctrl_alu_src,
    input  logic              id_ex_ctrl_alu_shift_shamt,
    input  logic              id_ex_ctrl_branch,
    input  logic              id_ex_ctrl_jump,
    input  logic              id_ex_ctrl_jump_reg,
    input  logic              id_ex_ctrl_mem_to_reg,
    input  logic              id_ex_ctrl_mem_write,
    input  logic              id_ex_ctrl_reg_dst,
    input  logic              id_ex_ctrl_reg_write,
    input  logic [2:0]        id_ex_ctrl_load_type,
    input  logic [2:0]        id_ex_ctrl_branch_type,
    input  logic [1:0]        id_ex_ctrl_store_type,
    input  logic              mem_wb_reg_write,
    input  logic [4:0]        mem_wb_write_reg,
    input  logic [DATA_W-1:0] mem_wb_write_data,
    input  logic              mem_stall,
    output logic [DATA_W-1:0] ex_mem_alu_result,
    output logic [DATA_W-1:0] ex_mem_store_data,
    output logic [4:0]        ex_mem_write_reg,
    output logic              ex_mem_ctrl_reg_write,
    output logic              ex_mem_ctrl_mem_to_reg,
    output logic              ex_mem_ctrl_mem_write,
    output logic [2:0]        ex_mem_ctrl_load_type,
    output logic [1:0]        ex_mem_ctrl_store_type,
    output logic              pc_redirect,
    output logic [DATA_W-1:0] pc_target,
    output logic              flush_id
);

    logic [DATA_W-1:0] exMemAluResult_q, exMemAluResult_d;
    logic [DATA_W-1:0] exMemStoreData_q, exMemStoreData_d;
    logic [4:0]        exMemWriteReg_q, exMemWriteReg_d;
    logic              exMemRegWrite_q, exMemMemToReg_q, exMemMemWrite_q;
    logic [2:0]        exMemLoadType_q;
    logic [1:0]        exMemStoreType_q;

    logic [DATA_W-1:0] fwdA, fwdB, aluB, aluResult;
    logic [DATA_W-1:0] branchTarget, jumpTarget, selTarget;
    logic [4:0]        shiftAmt;
    logic              branchTaken, redirectRaw;
    logic              exMemFwdOk;

    // Loads in EX/MEM have no data yet; those hazards are stalled upstream.
    assign exMemFwdOk = exMemRegWrite_q && (exMemWriteReg_q != 5'd0) && !exMemMemToReg_q;

    always_comb begin
        fwdA = id_ex_reg_a_data;
        if (exMemFwdOk && (exMemWriteReg_q == id_ex_rs))
            fwdA = exMemAluResult_q;
        else if (mem_wb_reg_write && (mem_wb_write_reg != 5'd0) && (mem_wb_write_reg == id_ex_rs))
            fwdA = mem_wb_write_data;
    end

    always_comb begin
        fwdB = id_ex_reg_b_data;
        if (exMemFwdOk && (exMemWriteReg_q == id_ex_rt))
            fwdB = exMemAluResult_q;
        else if (mem_wb_reg_write && (mem_wb_write_reg != 5'd0) && (mem_wb_write_reg == id_ex_rt))
            fwdB = mem_wb_write_data;
    end

    assign aluB     = id_ex_ctrl_alu_src ? id_ex_imm_sign_extended : fwdB;
    assign shiftAmt = id_ex_ctrl_alu_shift_shamt ? id_ex_shamt : fwdA[4:0];

    always_comb begin
        aluResult = '0;
        case (id_ex_ctrl_alu_control)
            4'd0:  aluResult = fwdA + aluB;
            4'd1:  aluResult = fwdA - aluB;
            4'd2:  aluResult = fwdA & aluB;
            4'd3:  aluResult = fwdA | aluB;
            4'd4:  aluResult = fwdA ^ aluB;
            4'd5:  aluResult = ~(fwdA | aluB);
            4'd6:  aluResult = {{(DATA_W-1){1'b0}}, ($signed(fwdA) < $signed(aluB))};
            4'd7:  aluResult = {{(DATA_W-1){1'b0}}, (fwdA < aluB)};
            4'd8:  aluResult = aluB << shiftAmt;
            4'd9:  aluResult = aluB >> shiftAmt;
            4'd10: aluResult = $signed(aluB) >>> shiftAmt;
            4'd11: aluResult = {aluB[15:0], 16'h0000};
            default: aluResult = '0;
        endcase
    end

    // Branch comparisons use the forwarded operands, not the raw register reads.
    always_comb begin
        branchTaken = 1'b0;
        case (id_ex_ctrl_branch_type)
            3'd0: branchTaken = (fwdA == fwdB);
            3'd1: branchTaken = (fwdA != fwdB);
            3'd2: branchTaken = fwdA[DATA_W-1] || (fwdA == '0);
            3'd3: branchTaken = !fwdA[DATA_W-1] && (fwdA != '0);
            3'd4: branchTaken = fwdA[DATA_W-1];
            3'd5: branchTaken = !fwdA[DATA_W-1];
            default: branchTaken = 1'b0;
        endcase
    end

    assign branchTarget = id_ex_pc_next + (id_ex_imm_sign_extended << 2);
    assign jumpTarget   = {id_ex_pc_next[31:28], id_ex_jump_index, 2'b00};
    assign selTarget    = id_ex_ctrl_jump_reg ? fwdA :
                          id_ex_ctrl_jump     ? jumpTarget : branchTarget;
    assign redirectRaw  = id_ex_ctrl_jump_reg || id_ex_ctrl_jump ||
                          (id_ex_ctrl_branch && branchTaken);

    // A stalled instruction has not advanced, so its control flow waits too.
    assign pc_redirect = redirectRaw && !mem_stall;
    assign pc_target   = pc_redirect ? selTarget : '0;
    assign flush_id    = pc_redirect;

    assign exMemAluResult_d = aluResult;
    assign exMemStoreData_d = fwdB;
    assign exMemWriteReg_d  = id_ex_ctrl_reg_dst ? id_ex_rd : id_ex_rt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exMemAluResult_q <= '0;
            exMemStoreData_q <= '0;
            exMemWriteReg_q  <= '0;
            exMemRegWrite_q  <= 1'b0;
            exMemMemToReg_q  <= 1'b0;
            exMemMemWrite_q  <= 1'b0;
            exMemLoadType_q  <= '0;
            exMemStoreType_q <= '0;
        end else if (!mem_stall) begin
            exMemAluResult_q <= exMemAluResult_d;
            exMemStoreData_q <= exMemStoreData_d;
            exMemWriteReg_q  <= exMemWriteReg_d;
            exMemRegWrite_q  <= id_ex_ctrl_reg_write;
            exMemMemToReg_q  <= id_ex_ctrl_mem_to_reg;
            exMemMemWrite_q  <= id_ex_ctrl_mem_write;
            exMemLoadType_q  <= id_ex_ctrl_load_type;
            exMemStoreType_q <= id_ex_ctrl_store_type;
        end
    end

    assign ex_mem_alu_result      = exMemAluResult_q;
    assign ex_mem_store_data      = exMemStoreData_q;
    assign ex_mem_write_reg       = exMemWriteReg_q;
    assign ex_mem_ctrl_reg_write  = exMemRegWrite_q;
    assign ex_mem_ctrl_mem_to_reg = exMemMemToReg_q;
    assign ex_mem_ctrl_mem_write  = exMemMemWrite_q;
    assign ex_mem_ctrl_load_type  = exMemLoadType_q;
    assign ex_mem_ctrl_store_type = exMemStoreType_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage: forwarding, ALU, branch/jump, stall, reset.
module tb_ex_stage;

    logic        clk, rst_n;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] imm, regA, regB, pcNext;
    logic [25:0] jIdx;
    logic [3:0]  aluCtl;
    logic        aluSrc, shiftShamt, branch, jump, jumpReg, memToReg, memWrite, regDst, regWrite;
    logic [2:0]  loadType, branchType;
    logic [1:0]  storeType;
    logic        wbRegWrite;
    logic [4:0]  wbWriteReg;
    logic [31:0] wbWriteData;
    logic        memStall;
    logic [31:0] exAlu, exStore, pcTarget;
    logic [4:0]  exWriteReg;
    logic        exRegWrite, exMemToReg, exMemWrite, pcRedirect, flushId;
    logic [2:0]  exLoadType;
    logic [1:0]  exStoreType;

    int checkCount = 0;
    int passCount  = 0;

    ex_stage #(.DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_ex_rs(rs), .id_ex_rt(rt), .id_ex_rd(rd), .id_ex_shamt(shamt),
        .id_ex_imm_sign_extended(imm), .id_ex_jump_index(jIdx),
        .id_ex_reg_a_data(regA), .id_ex_reg_b_data(regB), .id_ex_pc_next(pcNext),
        .id_ex_ctrl_alu_control(aluCtl), .id_ex_ctrl_alu_src(aluSrc),
        .id_ex_ctrl_alu_shift_shamt(shiftShamt), .id_ex_ctrl_branch(branch),
        .id_ex_ctrl_jump(jump), .id_ex_ctrl_jump_reg(jumpReg),
        .id_ex_ctrl_mem_to_reg(memToReg), .id_ex_ctrl_mem_write(memWrite),
        .id_ex_ctrl_reg_dst(regDst), .id_ex_ctrl_reg_write(regWrite),
        .id_ex_ctrl_load_type(loadType), .id_ex_ctrl_branch_type(branchType),
        .id_ex_ctrl_store_type(storeType),
        .mem_wb_reg_write(wbRegWrite), .mem_wb_write_reg(wbWriteReg),
        .mem_wb_write_data(wbWriteData), .mem_stall(memStall),
        .ex_mem_alu_result(exAlu), .ex_mem_store_data(exStore),
        .ex_mem_write_reg(exWriteReg), .ex_mem_ctrl_reg_write(exRegWrite),
        .ex_mem_ctrl_mem_to_reg(exMemToReg), .ex_mem_ctrl_mem_write(exMemWrite),
        .ex_mem_ctrl_load_type(exLoadType), .ex_mem_ctrl_store_type(exStoreType),
        .pc_redirect(pcRedirect), .pc_target(pcTarget), .flush_id(flushId)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clearInputs();
        rs = 0; rt = 0; rd = 0; shamt = 0; imm = 0; regA = 0; regB = 0; pcNext = 0; jIdx = 0;
        aluCtl = 0; aluSrc = 0; shiftShamt = 0; branch = 0; jump = 0; jumpReg = 0;
        memToReg = 0; memWrite = 0; regDst = 0; regWrite = 0;
        loadType = 0; branchType = 0; storeType = 0;
        wbRegWrite = 0; wbWriteReg = 0; wbWriteData = 0; memStall = 0;
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clearInputs();
        step();
        step();
        checkCount++;
        if ({exAlu, exStore, exWriteReg, exRegWrite, exMemToReg, exMemWrite, exLoadType, exStoreType} !== 80'd0)
            $display("[TB] FAIL reset_exmem: got alu=%h st=%h wr=%0d ctl=%b%b%b lt=%0d stt=%0d expected all 0",
                     exAlu, exStore, exWriteReg, exRegWrite, exMemToReg, exMemWrite, exLoadType, exStoreType);
        else passCount++;
        checkCount++;
        if ({pcRedirect, flushId, pcTarget} !== 34'd0)
            $display("[TB] FAIL reset_redirect: got redir=%b flush=%b tgt=%h expected 0", pcRedirect, flushId, pcTarget);
        else passCount++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_forwarding();
        clearInputs();
        // add $3,$1,$2
        rs = 1; rt = 2; rd = 3; regA = 1; regB = 2; regDst = 1; regWrite = 1;
        step();
        checkCount++;
        if (exAlu !== 32'd3 || exWriteReg !== 5'd3 || exRegWrite !== 1'b1)
            $display("[TB] FAIL add_basic: got alu=%0d wr=%0d rw=%b expected 3/3/1", exAlu, exWriteReg, exRegWrite);
        else passCount++;
        // add $4,$3,$3 with a competing MEM/WB write to $3
        rs = 3; rt = 3; rd = 4; regA = 0; regB = 0;
        wbRegWrite = 1; wbWriteReg = 3; wbWriteData = 99;
        step();
        checkCount++;
        if (exAlu !== 32'd6 || exWriteReg !== 5'd4)
            $display("[TB] FAIL fwd_ex_priority: got alu=%0d wr=%0d expected 6/4", exAlu, exWriteReg);
        else passCount++;
        checkCount++;
        if (exStore !== 32'd3)
            $display("[TB] FAIL fwd_store_data: got %0d expected 3", exStore);
        else passCount++;
        // rs=$3 only in MEM/WB now, rt=$4 in EX/MEM -> 99 + 6
        rs = 3; rt = 4; rd = 5;
        step();
        checkCount++;
        if (exAlu !== 32'd105)
            $display("[TB] FAIL fwd_mixed: got %0d expected 105", exAlu);
        else passCount++;
        // load into $7: EX/MEM must not forward its address
        clearInputs();
        rt = 7; aluSrc = 1; imm = 32'h40; regWrite = 1; memToReg = 1; loadType = 3'd2;
        step();
        checkCount++;
        if (exAlu !== 32'h40 || exWriteReg !== 5'd7 || exMemToReg !== 1'b1 || exLoadType !== 3'd2)
            $display("[TB] FAIL load_addr: got alu=%h wr=%0d m2r=%b lt=%0d expected 40/7/1/2",
                     exAlu, exWriteReg, exMemToReg, exLoadType);
        else passCount++;
        clearInputs();
        rs = 7; regA = 11;
        step();
        checkCount++;
        if (exAlu !== 32'd11)
            $display("[TB] FAIL no_load_fwd: got %0d expected 11", exAlu);
        else passCount++;
    endtask

    task automatic test_zero_guard();
        clearInputs();
        regA = 5; regB = 5; regDst = 1; rd = 0; regWrite = 1;
        step();
        clearInputs();
        wbRegWrite = 1; wbWriteReg = 0; wbWriteData = 77;
        step();
        checkCount++;
        if (exAlu !== 32'd0)
            $display("[TB] FAIL zero_guard: got %0d expected 0", exAlu);
        else passCount++;
        checkCount++;
        if ({exRegWrite, exMemToReg, exMemWrite, exLoadType, exStoreType} !== 8'd0)
            $display("[TB] FAIL bubble_ctrl: got %b expected 0",
                     {exRegWrite, exMemToReg, exMemWrite, exLoadType, exStoreType});
        else passCount++;
    endtask

    task automatic test_branch();
        clearInputs();
        step();
        branch = 1; branchType = 3'd1; rs = 1; rt = 2; regA = 5; regB = 7;
        pcNext = 32'h100; imm = 32'hFFFF_FFFE;
        #1;
        checkCount++;
        if (pcRedirect !== 1'b1 || flushId !== 1'b1 || pcTarget !== 32'hF8)
            $display("[TB] FAIL bne_taken: got redir=%b flush=%b tgt=%h expected 1/1/000000f8",
                     pcRedirect, flushId, pcTarget);
        else passCount++;
        regB = 5;
        #1;
        checkCount++;
        if (pcRedirect !== 1'b0 || flushId !== 1'b0 || pcTarget !== 32'h0)
            $display("[TB] FAIL bne_not_taken: got redir=%b flush=%b tgt=%h expected 0/0/0",
                     pcRedirect, flushId, pcTarget);
        else passCount++;
        branchType = 3'd2; regA = 0;
        #1;
        checkCount++;
        if (pcRedirect !== 1'b1)
            $display("[TB] FAIL blez_zero: got %b expected 1", pcRedirect);
        else passCount++;
        branchType = 3'd3;
        #1;
        checkCount++;
        if (pcRedirect !== 1'b0)
            $display("[TB] FAIL bgtz_zero: got %b expected 0", pcRedirect);
        else passCount++;
        branchType = 3'd4; regA = 32'h8000_0000;
        #1;
        checkCount++;
        if (pcRedirect !== 1'b1)
            $display("[TB] FAIL bltz_neg: got %b expected 1", pcRedirect);
        else passCount++;
        branchType = 3'd6; regA = 5; regB = 5;
        #1;
        checkCount++;
        if (pcRedirect !== 1'b0)
            $display("[TB] FAIL btype6_never: got %b expected 0", pcRedirect);
        else passCount++;
    endtask

    task automatic test_jump();
        clearInputs();
        step();
        jump = 1; jumpReg = 1; rs = 1; regA = 32'h0040_0020;
        pcNext = 32'h9000_0004; jIdx = 26'h10;
        #1;
        checkCount++;
        if (pcRedirect !== 1'b1 || pcTarget !== 32'h0040_0020)
            $display("[TB] FAIL jr_priority: got redir=%b tgt=%h expected 1/00400020", pcRedirect, pcTarget);
        else passCount++;
        jumpReg = 0; branch = 1; branchType = 3'd0;
        #1;
        checkCount++;
        if (pcRedirect !== 1'b1 || pcTarget !== 32'h9000_0040)
            $display("[TB] FAIL j_target: got redir=%b tgt=%h expected 1/90000040", pcRedirect, pcTarget);
        else passCount++;
    endtask

    task automatic test_alu_ops();
        clearInputs();
        rs = 1; rt = 2;
        aluCtl = 4'd10; shiftShamt = 1; shamt = 4; regB = 32'h8000_0000;
        step();
        checkCount++;
        if (exAlu !== 32'hF800_0000)
            $display("[TB] FAIL sra: got %h expected f8000000", exAlu);
        else passCount++;
        aluCtl = 4'd9; shamt = 31;
        step();
        checkCount++;
        if (exAlu !== 32'h1)
            $display("[TB] FAIL srl: got %h expected 00000001", exAlu);
        else passCount++;
        aluCtl = 4'd8; shiftShamt = 0; regA = 3; regB = 1;
        step();
        checkCount++;
        if (exAlu !== 32'h8)
            $display("[TB] FAIL sllv: got %h expected 00000008", exAlu);
        else passCount++;
        aluCtl = 4'd7; regA = 1; regB = 32'hFFFF_FFFF;
        step();
        checkCount++;
        if (exAlu !== 32'h1)
            $display("[TB] FAIL sltu: got %h expected 00000001", exAlu);
        else passCount++;
        aluCtl = 4'd6;
        step();
        checkCount++;
        if (exAlu !== 32'h0)
            $display("[TB] FAIL slt: got %h expected 00000000", exAlu);
        else passCount++;
        aluCtl = 4'd1; regA = 5; regB = 7;
        step();
        checkCount++;
        if (exAlu !== 32'hFFFF_FFFE)
            $display("[TB] FAIL sub_wrap: got %h expected fffffffe", exAlu);
        else passCount++;
        aluCtl = 4'd5; regA = 32'h0F0F_0000; regB = 32'h0000_00FF;
        step();
        checkCount++;
        if (exAlu !== 32'hF0F0_FF00)
            $display("[TB] FAIL nor: got %h expected f0f0ff00", exAlu);
        else passCount++;
        aluCtl = 4'd11; aluSrc = 1; imm = 32'h0000_1234;
        step();
        checkCount++;
        if (exAlu !== 32'h1234_0000)
            $display("[TB] FAIL lui: got %h expected 12340000", exAlu);
        else passCount++;
        aluCtl = 4'd13;
        step();
        checkCount++;
        if (exAlu !== 32'h0)
            $display("[TB] FAIL op13_zero: got %h expected 00000000", exAlu);
        else passCount++;
    endtask

    task automatic test_stall();
        clearInputs();
        rs = 1; rt = 2; rd = 3; regA = 1; regB = 2; regDst = 1; regWrite = 1;
        step();
        clearInputs();
        memStall = 1; branch = 1; branchType = 3'd0; rs = 1; rt = 2; regA = 10; regB = 10;
        pcNext = 32'h200; imm = 32'h4;
        #1;
        checkCount++;
        if (pcRedirect !== 1'b0 || flushId !== 1'b0)
            $display("[TB] FAIL stall_no_redirect: got redir=%b flush=%b expected 0/0", pcRedirect, flushId);
        else passCount++;
        step();
        step();
        checkCount++;
        if (exAlu !== 32'd3 || exWriteReg !== 5'd3 || exRegWrite !== 1'b1)
            $display("[TB] FAIL stall_hold: got alu=%0d wr=%0d rw=%b expected 3/3/1", exAlu, exWriteReg, exRegWrite);
        else passCount++;
        memStall = 0;
        #1;
        checkCount++;
        if (pcRedirect !== 1'b1 || pcTarget !== 32'h210)
            $display("[TB] FAIL stall_release_redirect: got redir=%b tgt=%h expected 1/00000210", pcRedirect, pcTarget);
        else passCount++;
        step();
        checkCount++;
        if (exAlu !== 32'd20 || exRegWrite !== 1'b0)
            $display("[TB] FAIL stall_release_load: got alu=%0d rw=%b expected 20/0", exAlu, exRegWrite);
        else passCount++;
    endtask

    task automatic test_reset_mid();
        clearInputs();
        rs = 1; rt = 2; rd = 9; regA = 4; regB = 6; regDst = 1;
        regWrite = 1; memToReg = 1; memWrite = 1; loadType = 3'd5; storeType = 2'd2;
        step();
        checkCount++;
        if (exAlu !== 32'd10 || exStore !== 32'd6 || exWriteReg !== 5'd9 || exMemWrite !== 1'b1 || exStoreType !== 2'd2)
            $display("[TB] FAIL preload: got alu=%0d st=%0d wr=%0d mw=%b stt=%0d expected 10/6/9/1/2",
                     exAlu, exStore, exWriteReg, exMemWrite, exStoreType);
        else passCount++;
        #2;
        rst_n = 1'b0;
        #1;
        checkCount++;
        if ({exAlu, exStore, exWriteReg, exRegWrite, exMemToReg, exMemWrite, exLoadType, exStoreType} !== 80'd0)
            $display("[TB] FAIL async_reset: got alu=%h st=%h wr=%0d ctl=%b%b%b lt=%0d stt=%0d expected all 0",
                     exAlu, exStore, exWriteReg, exRegWrite, exMemToReg, exMemWrite, exLoadType, exStoreType);
        else passCount++;
        step();
        rst_n = 1'b1;
        clearInputs();
        step();
        checkCount++;
        if (exAlu !== 32'd0 || exRegWrite !== 1'b0)
            $display("[TB] FAIL post_reset: got alu=%0d rw=%b expected 0/0", exAlu, exRegWrite);
        else passCount++;
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_zero_guard();
        test_branch();
        test_jump();
        test_alu_ops();
        test_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
